// File: rtl/saxil_read_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite slave read port between two masters.
// One transaction is in flight at a time: the winner's AR is latched and replayed
// to the slave, and the slave's R beat is routed back only to the granted master.
module saxil_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  saxil_read_arb_clk,
  input  logic                  saxil_read_arb_rst_n,
  input  logic                  saxil_read_arb_m0_arvalid,
  output logic                  saxil_read_arb_m0_arready,
  input  logic [ADDR_WIDTH-1:0] saxil_read_arb_m0_araddr,
  input  logic [2:0]            saxil_read_arb_m0_arprot,
  output logic                  saxil_read_arb_m0_rvalid,
  input  logic                  saxil_read_arb_m0_rready,
  output logic [DATA_WIDTH-1:0] saxil_read_arb_m0_rdata,
  output logic [1:0]            saxil_read_arb_m0_rresp,
  input  logic                  saxil_read_arb_m1_arvalid,
  output logic                  saxil_read_arb_m1_arready,
  input  logic [ADDR_WIDTH-1:0] saxil_read_arb_m1_araddr,
  input  logic [2:0]            saxil_read_arb_m1_arprot,
  output logic                  saxil_read_arb_m1_rvalid,
  input  logic                  saxil_read_arb_m1_rready,
  output logic [DATA_WIDTH-1:0] saxil_read_arb_m1_rdata,
  output logic [1:0]            saxil_read_arb_m1_rresp,
  output logic                  saxil_read_arb_s_arvalid,
  input  logic                  saxil_read_arb_s_arready,
  output logic [ADDR_WIDTH-1:0] saxil_read_arb_s_araddr,
  output logic [2:0]            saxil_read_arb_s_arprot,
  input  logic                  saxil_read_arb_s_rvalid,
  output logic                  saxil_read_arb_s_rready,
  input  logic [DATA_WIDTH-1:0] saxil_read_arb_s_rdata,
  input  logic [1:0]            saxil_read_arb_s_rresp,
  output logic                  saxil_read_arb_busy,
  output logic                  saxil_read_arb_grant
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  grant_q, grant_d;
  logic                  s_arvalid_q, s_arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [2:0]            arprot_q, arprot_d;
  logic                  req_any;
  logic                  winner;

  // Pick the winner: a lone requester wins outright, a tie goes to the pointer.
  always_comb begin
    req_any = saxil_read_arb_m0_arvalid | saxil_read_arb_m1_arvalid;
    winner  = (saxil_read_arb_m0_arvalid && saxil_read_arb_m1_arvalid) ? ptr_q
                                                                       : saxil_read_arb_m1_arvalid;
  end

  // State, pointer, grant and the replayed slave AR registers.
  always_ff @(posedge saxil_read_arb_clk or negedge saxil_read_arb_rst_n) begin
    if (!saxil_read_arb_rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      grant_q     <= 1'b0;
      s_arvalid_q <= 1'b0;
      araddr_q    <= '0;
      arprot_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      s_arvalid_q <= s_arvalid_d;
      araddr_q    <= araddr_d;
      arprot_q    <= arprot_d;
    end
  end

  // Next-state logic plus the combinational handshakes and R-channel routing.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    s_arvalid_d = s_arvalid_q;
    araddr_d    = araddr_q;
    arprot_d    = arprot_q;

    saxil_read_arb_m0_arready = 1'b0;
    saxil_read_arb_m1_arready = 1'b0;
    saxil_read_arb_m0_rvalid  = 1'b0;
    saxil_read_arb_m0_rdata   = '0;
    saxil_read_arb_m0_rresp   = 2'b00;
    saxil_read_arb_m1_rvalid  = 1'b0;
    saxil_read_arb_m1_rdata   = '0;
    saxil_read_arb_m1_rresp   = 2'b00;
    saxil_read_arb_s_rready   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_any) begin
          saxil_read_arb_m0_arready = ~winner;
          saxil_read_arb_m1_arready = winner;
          state_d     = ADDR;
          grant_d     = winner;
          s_arvalid_d = 1'b1;
          araddr_d    = winner ? saxil_read_arb_m1_araddr : saxil_read_arb_m0_araddr;
          arprot_d    = winner ? saxil_read_arb_m1_arprot : saxil_read_arb_m0_arprot;
        end
      end
      ADDR: begin
        if (saxil_read_arb_s_arready) begin
          s_arvalid_d = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (grant_q) begin
          saxil_read_arb_m1_rvalid = saxil_read_arb_s_rvalid;
          saxil_read_arb_m1_rdata  = saxil_read_arb_s_rdata;
          saxil_read_arb_m1_rresp  = saxil_read_arb_s_rresp;
          saxil_read_arb_s_rready  = saxil_read_arb_m1_rready;
        end else begin
          saxil_read_arb_m0_rvalid = saxil_read_arb_s_rvalid;
          saxil_read_arb_m0_rdata  = saxil_read_arb_s_rdata;
          saxil_read_arb_m0_rresp  = saxil_read_arb_s_rresp;
          saxil_read_arb_s_rready  = saxil_read_arb_m0_rready;
        end
        if (saxil_read_arb_s_rvalid && saxil_read_arb_s_rready) begin
          state_d = IDLE;
          ptr_d   = ~grant_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign saxil_read_arb_s_arvalid = s_arvalid_q;
  assign saxil_read_arb_s_araddr  = araddr_q;
  assign saxil_read_arb_s_arprot  = arprot_q;
  assign saxil_read_arb_busy      = (state_q != IDLE);
  assign saxil_read_arb_grant     = grant_q;

endmodule

// File: tb/tb_saxil_read_arbiter.sv
// Scoreboard bench for saxil_read_arbiter: directed stimulus pushes expected
// slave-AR and master-R beats into queues, a negedge monitor pops and compares.
module tb_saxil_read_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  prot;
  } ar_exp_t;

  typedef struct {
    logic        master;
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  logic        clk;
  logic        rst_n;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [31:0] m0_araddr, m0_rdata;
  logic [2:0]  m0_arprot;
  logic [1:0]  m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [31:0] m1_araddr, m1_rdata;
  logic [2:0]  m1_arprot;
  logic [1:0]  m1_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_araddr, s_rdata;
  logic [2:0]  s_arprot;
  logic [1:0]  s_rresp;
  logic        busy, grant;

  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];
  int      n_tests = 0;
  int      n_fail  = 0;

  saxil_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .saxil_read_arb_clk        (clk),
    .saxil_read_arb_rst_n      (rst_n),
    .saxil_read_arb_m0_arvalid (m0_arvalid),
    .saxil_read_arb_m0_arready (m0_arready),
    .saxil_read_arb_m0_araddr  (m0_araddr),
    .saxil_read_arb_m0_arprot  (m0_arprot),
    .saxil_read_arb_m0_rvalid  (m0_rvalid),
    .saxil_read_arb_m0_rready  (m0_rready),
    .saxil_read_arb_m0_rdata   (m0_rdata),
    .saxil_read_arb_m0_rresp   (m0_rresp),
    .saxil_read_arb_m1_arvalid (m1_arvalid),
    .saxil_read_arb_m1_arready (m1_arready),
    .saxil_read_arb_m1_araddr  (m1_araddr),
    .saxil_read_arb_m1_arprot  (m1_arprot),
    .saxil_read_arb_m1_rvalid  (m1_rvalid),
    .saxil_read_arb_m1_rready  (m1_rready),
    .saxil_read_arb_m1_rdata   (m1_rdata),
    .saxil_read_arb_m1_rresp   (m1_rresp),
    .saxil_read_arb_s_arvalid  (s_arvalid),
    .saxil_read_arb_s_arready  (s_arready),
    .saxil_read_arb_s_araddr   (s_araddr),
    .saxil_read_arb_s_arprot   (s_arprot),
    .saxil_read_arb_s_rvalid   (s_rvalid),
    .saxil_read_arb_s_rready   (s_rready),
    .saxil_read_arb_s_rdata    (s_rdata),
    .saxil_read_arb_s_rresp    (s_rresp),
    .saxil_read_arb_busy       (busy),
    .saxil_read_arb_grant      (grant)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [2:0] p0,
                               input logic v1, input logic [31:0] a1, input logic [2:0] p1);
    m0_arvalid = v0;
    m0_araddr  = a0;
    m0_arprot  = p0;
    m1_arvalid = v1;
    m1_araddr  = a1;
    m1_arprot  = p1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expectAr(input logic [31:0] addr, input logic [2:0] prot);
    ar_exp_t e;
    e.addr = addr;
    e.prot = prot;
    ar_q.push_back(e);
  endtask

  task automatic expectR(input logic master, input logic [31:0] data, input logic [1:0] resp);
    r_exp_t e;
    e.master = master;
    e.data   = data;
    e.resp   = resp;
    r_q.push_back(e);
  endtask

  task automatic popR(input logic master, input logic [31:0] data, input logic [1:0] resp);
    r_exp_t e;
    n_tests++;
    if (r_q.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL r_unexpected: master %0d got beat %h, expected no beat", master, data);
    end else begin
      e = r_q.pop_front();
      checkOutput("r_master", 32'(master), 32'(e.master));
      checkOutput("r_data", data, e.data);
      checkOutput("r_resp", 32'(resp), 32'(e.resp));
    end
  endtask

  // Monitor: every completed slave-AR or master-R handshake must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_arvalid && s_arready) begin
        ar_exp_t e;
        n_tests++;
        if (ar_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL ar_unexpected: got addr %h, expected no AR", s_araddr);
        end else begin
          e = ar_q.pop_front();
          checkOutput("ar_addr", s_araddr, e.addr);
          checkOutput("ar_prot", 32'(s_arprot), 32'(e.prot));
        end
      end
      if (m0_rvalid && m0_rready) popR(1'b0, m0_rdata, m0_rresp);
      if (m1_rvalid && m1_rready) popR(1'b1, m1_rdata, m1_rresp);
    end
  end

  // Slave side of one transaction, entered one step after the AR was accepted.
  task automatic serveTxn(input logic [31:0] data, input logic [1:0] resp, input logic master);
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    s_rvalid  = 1'b1;
    s_rdata   = data;
    s_rresp   = resp;
    m0_rready = 1'b1;
    m1_rready = 1'b1;
    expectR(master, data, resp);
    #1;
    checkOutput("serve_rdata", master ? m1_rdata : m0_rdata, data);
    checkOutput("serve_other_rvalid", 32'(master ? m0_rvalid : m1_rvalid), 32'd0);
    tick();
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rresp   = 2'b00;
    m0_rready = 1'b0;
    m1_rready = 1'b0;
  endtask

  // Directed stimulus sequence.
  initial begin
    rst_n     = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    m0_rready = 1'b0;
    m1_rready = 1'b0;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rresp   = 2'b00;
    tick();
    tick();
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_s_arvalid", 32'(s_arvalid), 32'd0);
    checkOutput("rst_s_araddr", s_araddr, 32'd0);
    checkOutput("rst_s_rready", 32'(s_rready), 32'd0);
    checkOutput("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single master on an all-ones address.
    applyStimulus(1'b1, 32'hFFFF_FFFF, 3'd0, 1'b0, '0, '0);
    #1;
    checkOutput("single_m0_arready", 32'(m0_arready), 32'd1);
    checkOutput("single_m1_arready", 32'(m1_arready), 32'd0);
    checkOutput("single_s_arvalid_early", 32'(s_arvalid), 32'd0);
    expectAr(32'hFFFF_FFFF, 3'd0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    checkOutput("single_s_arvalid", 32'(s_arvalid), 32'd1);
    checkOutput("single_s_araddr", s_araddr, 32'hFFFF_FFFF);
    checkOutput("single_busy", 32'(busy), 32'd1);
    serveTxn(32'hDEAD_BEEF, 2'b00, 1'b0);
    checkOutput("single_grant", 32'(grant), 32'd0);
    checkOutput("single_idle", 32'(busy), 32'd0);

    // Simultaneous requests held from reset: m0, then m1, then m0 again.
    rst_n = 1'b0;
    applyStimulus(1'b1, 32'hF0F0_F0F0, 3'd1, 1'b1, 32'h0000_1234, 3'd2);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("tie_m0_arready", 32'(m0_arready), 32'd1);
    checkOutput("tie_m1_arready", 32'(m1_arready), 32'd0);
    expectAr(32'hF0F0_F0F0, 3'd1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b1, 32'h0000_1234, 3'd2);
    #1;
    checkOutput("tie_m1_stalled", 32'(m1_arready), 32'd0);
    serveTxn(32'h1111_0000, 2'b00, 1'b0);
    #1;
    checkOutput("tie_m1_arready_next", 32'(m1_arready), 32'd1);
    checkOutput("tie_grant_held", 32'(grant), 32'd0);
    expectAr(32'h0000_1234, 3'd2);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("tie_grant_m1", 32'(grant), 32'd1);
    serveTxn(32'h2222_0000, 2'b00, 1'b1);
    applyStimulus(1'b1, 32'hA000_0000, 3'd0, 1'b1, 32'hB000_0000, 3'd7);
    #1;
    checkOutput("tie3_m0_arready", 32'(m0_arready), 32'd1);
    checkOutput("tie3_m1_arready", 32'(m1_arready), 32'd0);
    expectAr(32'hA000_0000, 3'd0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b1, 32'hB000_0000, 3'd7);

    // Slave AR backpressure: four stalled cycles then accept.
    for (int i = 0; i < 5; i++) begin
      s_arready = (i == 4);
      #1;
      checkOutput("arstall_s_arvalid", 32'(s_arvalid), 32'd1);
      checkOutput("arstall_s_araddr", s_araddr, 32'hA000_0000);
      checkOutput("arstall_busy", 32'(busy), 32'd1);
      checkOutput("arstall_m1_arready", 32'(m1_arready), 32'd0);
      tick();
    end
    s_arready = 1'b0;

    // Error response passthrough to m0.
    s_rvalid  = 1'b1;
    s_rdata   = 32'h3333_0000;
    s_rresp   = 2'b10;
    m0_rready = 1'b1;
    expectR(1'b0, 32'h3333_0000, 2'b10);
    #1;
    checkOutput("slverr_m0_rresp", 32'(m0_rresp), 32'd2);
    checkOutput("slverr_m1_rvalid", 32'(m1_rvalid), 32'd0);
    tick();
    s_rvalid  = 1'b0;
    s_rresp   = 2'b00;
    m0_rready = 1'b0;
    checkOutput("slverr_idle", 32'(busy), 32'd0);

    // Stalled m1 request is accepted now; then master R backpressure.
    #1;
    checkOutput("m1_late_arready", 32'(m1_arready), 32'd1);
    expectAr(32'hB000_0000, 3'd7);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    s_rvalid  = 1'b1;
    s_rdata   = 32'h0000_00A5;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("rstall_s_rready", 32'(s_rready), 32'd0);
      checkOutput("rstall_m1_rvalid", 32'(m1_rvalid), 32'd1);
      checkOutput("rstall_m1_rdata", m1_rdata, 32'h0000_00A5);
      checkOutput("rstall_m0_rvalid", 32'(m0_rvalid), 32'd0);
      tick();
    end
    m1_rready = 1'b1;
    expectR(1'b1, 32'h0000_00A5, 2'b00);
    #1;
    checkOutput("rstall_release", 32'(s_rready), 32'd1);
    tick();
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    m1_rready = 1'b0;
    checkOutput("rstall_idle", 32'(busy), 32'd0);
    checkOutput("rstall_grant", 32'(grant), 32'd1);

    // Reset in the middle of RESP discards the transaction.
    applyStimulus(1'b1, 32'h0000_0100, 3'd0, 1'b0, '0, '0);
    expectAr(32'h0000_0100, 3'd0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    s_rvalid  = 1'b1;
    s_rdata   = 32'h4444_0000;
    m0_rready = 1'b1;
    #1;
    checkOutput("mid_s_rready", 32'(s_rready), 32'd1);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_s_rready", 32'(s_rready), 32'd0);
    checkOutput("arst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    checkOutput("arst_m0_rdata", m0_rdata, 32'd0);
    checkOutput("arst_s_arvalid", 32'(s_arvalid), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_grant", 32'(grant), 32'd0);
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    m0_rready = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b1, 32'h0000_0200, 3'd3);
    #1;
    checkOutput("post_m1_arready", 32'(m1_arready), 32'd1);
    expectAr(32'h0000_0200, 3'd3);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("post_grant_m1", 32'(grant), 32'd1);
    serveTxn(32'h5555_0000, 2'b11, 1'b1);
    applyStimulus(1'b1, 32'h0000_0300, 3'd0, 1'b1, 32'h0000_0400, 3'd0);
    #1;
    checkOutput("post_tie_m0_arready", 32'(m0_arready), 32'd1);
    checkOutput("post_tie_m1_arready", 32'(m1_arready), 32'd0);
    expectAr(32'h0000_0300, 3'd0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("post_tie_grant", 32'(grant), 32'd0);
    serveTxn(32'h6666_0000, 2'b00, 1'b0);
    tick();

    checkOutput("ar_queue_drained", ar_q.size(), 32'd0);
    checkOutput("r_queue_drained", r_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
